// File: rtl/throw_trajectory.sv
// -----------------------------------------------------------------------------
// throw_trajectory
//
// Projectile motion generator. A launch strobe latches the throw force into a
// horizontal speed (leftward) and an upward vertical speed. The position then
// advances once per video frame under constant gravity. The flight ends on
// reaching the ground line or on crossing the left screen edge. After a
// landing the position is frozen for HOLD_FRAMES frames before the block
// returns to idle at the launch point.
//
// Optional feature macro: THROW_WIND_EN adds a signed wind input that biases
// the horizontal step (clamped to 0..127) and is sampled on every frame tick.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   throw_start    in   one-cycle launch strobe (accepted only in idle)
//   throw_force    in   [9:0] launch force, sampled with an accepted launch
//   frame_tick     in   one-cycle pulse per video frame
//   wind           in   [3:0] signed wind (THROW_WIND_EN builds only)
//   proj_x         out  [10:0] projectile x, unsigned
//   proj_y         out  [15:0] projectile y, signed
//   proj_active    out  high while in flight
//   busy           out  high while in flight or holding after landing
//   landed         out  one-cycle pulse when the flight ends
//   out_of_bounds  out  sticky: last flight ended at the left edge
// -----------------------------------------------------------------------------
module throw_trajectory #(
  parameter int X_START     = 900,
  parameter int Y_START     = 380,
  parameter int GROUND_Y    = 700,
  parameter int GRAVITY     = 1,
  parameter int HOLD_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               throw_start,
  input  logic [9:0]         throw_force,
  input  logic               frame_tick,
`ifdef THROW_WIND_EN
  input  logic signed [3:0]  wind,
`endif
  output logic [10:0]        proj_x,
  output logic signed [15:0] proj_y,
  output logic               proj_active,
  output logic               busy,
  output logic               landed,
  output logic               out_of_bounds
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLIGHT = 2'd1;
  localparam logic [1:0] S_LANDED = 2'd2;
  localparam int         HCW      = $clog2(HOLD_FRAMES + 1);

  logic [1:0]         r_state;
  logic [10:0]        r_x;
  logic signed [15:0] r_y;
  logic [6:0]         r_vx;
  logic signed [9:0]  r_vy;
  logic [HCW-1:0]     r_hold_cnt;
  logic               r_active;
  logic               r_busy;
  logic               r_landed;
  logic               r_oob;

  logic [6:0]         w_step;
  logic signed [11:0] w_nx;
  logic signed [15:0] w_ny;
  logic signed [10:0] w_vy_inc;
  logic signed [9:0]  w_vy_next;
  logic               w_unused;

  // The two low force bits never reach either velocity component.
  assign w_unused = ^throw_force[1:0];

`ifdef THROW_WIND_EN
  logic signed [8:0] w_step_raw;

  // Wind-adjusted horizontal step, clamped so the projectile never moves right.
  always_comb begin
    w_step_raw = $signed({2'b00, r_vx}) + 9'(wind);
    if (w_step_raw < 9'sd0) begin
      w_step = 7'd0;
    end else if (w_step_raw > 9'sd127) begin
      w_step = 7'd127;
    end else begin
      w_step = w_step_raw[6:0];
    end
  end
`else
  assign w_step = r_vx;
`endif

  // Candidate next position and gravity-updated vertical speed (saturating).
  // x only spans -127..2047 after one step, so 12 signed bits are exact.
  always_comb begin
    w_nx     = $signed({1'b0, r_x}) - $signed({5'b00000, w_step});
    w_ny     = r_y + 16'(r_vy);
    w_vy_inc = 11'(r_vy) + $signed(11'(GRAVITY));
    if (w_vy_inc > 11'sd511) begin
      w_vy_next = 10'sd511;
    end else begin
      w_vy_next = w_vy_inc[9:0];
    end
  end

  // Flight state machine, position/velocity registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= 11'(X_START);
      r_y        <= 16'(Y_START);
      r_vx       <= 7'd0;
      r_vy       <= 10'sd0;
      r_hold_cnt <= '0;
      r_active   <= 1'b0;
      r_busy     <= 1'b0;
      r_landed   <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      r_landed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x        <= 11'(X_START);
          r_y        <= 16'(Y_START);
          r_hold_cnt <= '0;
          if (throw_start) begin
            r_state  <= S_FLIGHT;
            r_vx     <= throw_force[9:3];
            r_vy     <= 10'sd0 - $signed({2'b00, throw_force[9:2]});
            r_oob    <= 1'b0;
            r_active <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_FLIGHT: begin
          if (frame_tick) begin
            // Left edge takes priority over the ground line.
            if (w_nx < 12'sd0) begin
              r_x      <= 11'd0;
              r_y      <= w_ny;
              r_oob    <= 1'b1;
              r_landed <= 1'b1;
              r_active <= 1'b0;
              r_state  <= S_LANDED;
            end else if (w_ny >= $signed(16'(GROUND_Y))) begin
              r_x      <= w_nx[10:0];
              r_y      <= 16'(GROUND_Y);
              r_landed <= 1'b1;
              r_active <= 1'b0;
              r_state  <= S_LANDED;
            end else begin
              r_x  <= w_nx[10:0];
              r_y  <= w_ny;
              r_vy <= w_vy_next;
            end
          end
        end
        S_LANDED: begin
          if (frame_tick) begin
            if (r_hold_cnt == HCW'(HOLD_FRAMES - 1)) begin
              r_hold_cnt <= '0;
              r_busy     <= 1'b0;
              r_x        <= 11'(X_START);
              r_y        <= 16'(Y_START);
              r_state    <= S_IDLE;
            end else begin
              r_hold_cnt <= r_hold_cnt + HCW'(1);
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_hold_cnt <= '0;
          r_active   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign proj_x        = r_x;
  assign proj_y        = r_y;
  assign proj_active   = r_active;
  assign busy          = r_busy;
  assign landed        = r_landed;
  assign out_of_bounds = r_oob;

endmodule

// File: doc/throw_trajectory.md
# throw_trajectory

Projectile motion generator sitting directly downstream of the charge-bar stage. It consumes the latched `throw_force` and a one-cycle launch strobe, then advances a projectile position once per video frame under constant gravity. Landing or leaving the left screen edge terminates the flight. The position outputs feed the projectile sprite renderer and hit-detection logic.

## Interface
Parameters:
- `X_START`, 900: launch x (pixels, unsigned).
- `Y_START`, 380: launch y (pixels).
- `GROUND_Y`, 700: landing line y.
- `GRAVITY`, 1: added to vertical velocity each frame.
- `HOLD_FRAMES`, 30: frames spent in LANDED before returning to IDLE.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `throw_start` in 1: one-cycle launch strobe, issued on space release.
- `throw_force` in 10: force value, sampled only when `throw_start` is accepted.
- `frame_tick` in 1: one-cycle pulse per frame (vsync start).
- `proj_x` out 11: projectile x, unsigned.
- `proj_y` out 16: projectile y, signed two's complement.
- `proj_active` out 1: high in FLIGHT.
- `busy` out 1: high in FLIGHT or LANDED.
- `landed` out 1: one-cycle pulse when the flight ends.
- `out_of_bounds` out 1: sticky flag; set when the flight ends at the left edge, cleared at the next launch.
- `wind` in 4: signed; present only with `THROW_WIND_EN`.

## Operation
- FSM states: IDLE, FLIGHT, LANDED.
- IDLE:
  - Outputs hold `proj_x=X_START`, `proj_y=Y_START`.
  - `throw_start` moves to FLIGHT. At that point the block sets `vx = throw_force>>3` (7-bit unsigned, 0..127) and `vy = -(throw_force>>2)` (10-bit signed, 0..-255), and clears `out_of_bounds`.
- FLIGHT, on each `frame_tick`, in this order:
  - `nx = x - vx`, `ny = y + vy` (16-bit signed arithmetic).
  - If `nx < 0`: `x <= 0`, `y <= ny`, set `out_of_bounds`, pulse `landed`, go to LANDED.
  - Else if `ny >= GROUND_Y`: `y <= GROUND_Y`, `x <= nx`, pulse `landed`, go to LANDED.
  - Else: `x <= nx`, `y <= ny`, `vy <= vy + GRAVITY`, with `vy` saturating at +511.
  - If the left-edge and ground conditions hold on the same tick, the left-edge case wins: `x=0`, `y=ny`, `out_of_bounds=1`.
- LANDED:
  - Position is frozen.
  - A frame counter counts `frame_tick`; after the `HOLD_FRAMES`-th tick the FSM returns to IDLE and the position resets to the start point.
- `throw_start` is ignored in FLIGHT and LANDED, and `throw_force` is not re-sampled.
- `proj_y` may go negative (above the screen). This is legal, not a termination condition.

## Timing
- All outputs are registered.
- Reset values: `proj_x=X_START`, `proj_y=Y_START`, `proj_active=0`, `busy=0`, `landed=0`, `out_of_bounds=0`; FSM in IDLE; hold counter at 0.
- `throw_start` at edge N: `proj_active` and `busy` are high after edge N+1.
- Position updates take effect on the edge after `frame_tick` is sampled, so latency is 1 cycle.
- A `frame_tick` in the same cycle as an accepted `throw_start` causes no motion. The first motion occurs on the next `frame_tick`.
- `landed` is high for exactly one cycle, on the same edge as the final position update.
- Asserting `rst` mid-flight returns the block to the reset state on the next edge. No `landed` pulse is generated.
- `frame_tick` pulses are at least 2 cycles apart.

## Configuration
- `THROW_WIND_EN` defined:
  - The `wind` port exists.
  - The horizontal step becomes `vx + wind`, sign-extended and clamped to 0..127; `wind` is sampled each `frame_tick`.
- `THROW_WIND_EN` undefined:
  - No `wind` port.
  - The horizontal step is `vx` exactly.

## Test plan
- Reset, then idle for 3 frames: outputs (900, 380), `busy=0`, no `landed` pulse.
- `throw_force=64`, launch, 1 tick: `vx=8`, `vy=-16`, position (892, 364), internal `vy=-15`. After tick 2: (884, 349).
- `throw_force=0`, launch: x stays 900. After tick 25, y=680. Tick 26 gives y=700 (clamped), a `landed` pulse, `out_of_bounds=0`.
- `throw_force=1023`, launch: after tick 7, x=11. Tick 8 gives x=0, `out_of_bounds=1`, `landed` pulse, y negative.
- `throw_start` mid-flight is ignored, and the trajectory is unchanged. After landing, exactly 30 ticks are spent in LANDED, then IDLE; the next launch clears `out_of_bounds`.
- `rst` at frame 5 of a flight: outputs return to reset values on the next edge, and no `landed` pulse occurs.
